// File: rtl/ik_request_sequencer.sv
// ik_request_sequencer: valid/ready front end that holds IK kernel inputs for LATENCY cycles and registers its results.
// Optional IK_REACH_CHECK_EN rejects out-of-reach or zero targets with out_err instead of running the kernel.
module ik_request_sequencer #(
    parameter int BIT_WIDTH = 32,
    parameter int FRACTIONS = 15,
    parameter int LATENCY   = 100,
    parameter int LAT_W     = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_x,
    input  logic [BIT_WIDTH-1:0] in_y,
    output logic [BIT_WIDTH-1:0] core_x,
    output logic [BIT_WIDTH-1:0] core_y,
    input  logic [BIT_WIDTH-1:0] core_theta1,
    input  logic [BIT_WIDTH-1:0] core_theta2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_theta1,
    output logic [BIT_WIDTH-1:0] out_theta2,
    output logic                 busy,
`ifdef IK_REACH_CHECK_EN
    output logic                 out_err,
`endif
    output logic [CNT_W-1:0]     txn_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    if ((LATENCY < 1) || (LATENCY >= (1 << LAT_W)) || (FRACTIONS >= BIT_WIDTH - 1)) begin : g_bad_param
        $error("ik_request_sequencer: illegal LATENCY/LAT_W/FRACTIONS");
    end

    state_t               state_q, state_d;
    logic [LAT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] core_x_q, core_x_d, core_y_q, core_y_d;
    logic [BIT_WIDTH-1:0] theta1_q, theta1_d, theta2_q, theta2_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_W-1:0]     txn_cnt_q, txn_cnt_d;
    logic                 err_q, err_d;
    logic                 accept, reject;

    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == OUT) && out_ready));
    assign accept   = in_valid && in_ready;

`ifdef IK_REACH_CHECK_EN
    localparam logic [BIT_WIDTH-2:0] REACH_MAX = (BIT_WIDTH-1)'(23) << FRACTIONS;
    logic [BIT_WIDTH-2:0] mag_x, mag_y;
    assign mag_x   = in_x[BIT_WIDTH-2:0];
    assign mag_y   = in_y[BIT_WIDTH-2:0];
    assign reject  = (mag_x > REACH_MAX) || (mag_y > REACH_MAX) || ((mag_x == '0) && (mag_y == '0));
    assign out_err = err_q;
`else
    assign reject  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        core_x_d    = core_x_q;
        core_y_d    = core_y_q;
        theta1_d    = theta1_q;
        theta2_d    = theta2_q;
        out_valid_d = out_valid_q;
        txn_cnt_d   = txn_cnt_q;
        err_d       = err_q;
        if (state_q == RUN) begin
            if (cnt_q == '0) begin
                theta1_d    = core_theta1;
                theta2_d    = core_theta2;
                err_d       = 1'b0;
                out_valid_d = 1'b1;
                txn_cnt_d   = txn_cnt_q + CNT_W'(1);
                state_d     = OUT;
            end else begin
                cnt_d = cnt_q - LAT_W'(1);
            end
        end
        if ((state_q == OUT) && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end
        // Accept overrides the retire above so OUT->RUN needs no bubble
        if (accept && reject) begin
            theta1_d    = '0;
            theta2_d    = '0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
            txn_cnt_d   = txn_cnt_q + CNT_W'(1);
            state_d     = OUT;
        end else if (accept) begin
            core_x_d = in_x;
            core_y_d = in_y;
            cnt_d    = LAT_W'(LATENCY - 1);
            state_d  = RUN;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            core_x_q    <= '0;
            core_y_q    <= '0;
            theta1_q    <= '0;
            theta2_q    <= '0;
            out_valid_q <= 1'b0;
            txn_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            core_x_q    <= core_x_d;
            core_y_q    <= core_y_d;
            theta1_q    <= theta1_d;
            theta2_q    <= theta2_d;
            out_valid_q <= out_valid_d;
            txn_cnt_q   <= txn_cnt_d;
            err_q       <= err_d;
        end
    end

    assign core_x     = core_x_q;
    assign core_y     = core_y_q;
    assign out_theta1 = theta1_q;
    assign out_theta2 = theta2_q;
    assign out_valid  = out_valid_q;
    assign txn_cnt    = txn_cnt_q;
    assign busy       = (state_q == RUN);

`ifndef IK_REACH_CHECK_EN
    logic unused_err;
    assign unused_err = err_q ^ reject;
`endif
endmodule

// File: tb/tb_ik_request_sequencer.sv
// tb_ik_request_sequencer: directed-vector bench for ik_request_sequencer with LATENCY=4 and a settable kernel stub.
module tb_ik_request_sequencer;
    localparam int BW  = 32;
    localparam int LAT = 4;
    localparam int CW  = 16;

    logic          clock = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready, busy;
    logic [BW-1:0] in_x, in_y, core_x, core_y, th1, th2, out_theta1, out_theta2;
    logic [CW-1:0] txn_cnt;
`ifdef IK_REACH_CHECK_EN
    logic          out_err;
`endif
    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ik_request_sequencer #(.BIT_WIDTH(BW), .FRACTIONS(15), .LATENCY(LAT), .LAT_W(8), .CNT_W(CW)) dut (
        .clock(clock), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .core_x(core_x), .core_y(core_y), .core_theta1(th1), .core_theta2(th2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_theta1(out_theta1), .out_theta2(out_theta2), .busy(busy),
`ifdef IK_REACH_CHECK_EN
        .out_err(out_err),
`endif
        .txn_cnt(txn_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_x = '0; in_y = '0; th1 = 32'hDEAD_BEEF; th2 = 32'hBAD0_BAD0;
        #1 rst = 1'b1;
        #1;
        check("rst_core_x", core_x, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_txn", txn_cnt, 0);
        check("rst_theta1", out_theta1, 0);
        step(2);
        rst = 1'b0;
        #1 check("idle_in_ready", in_ready, 1);
        step(3);
        check("idle_no_out", out_valid, 0);

        // single transaction; stub is garbage until just before the sample edge
        in_valid = 1'b1; in_x = 32'h0002_8000; in_y = 32'h0003_0000;
        step(1);
        in_valid = 1'b0; in_x = 32'h0000_1234; in_y = 32'h0000_5678;
        check("acc_core_x", core_x, 32'h0002_8000);
        check("acc_core_y", core_y, 32'h0003_0000);
        check("acc_busy", busy, 1);
        check("acc_in_ready", in_ready, 0);
        step(3);
        check("run_no_out", out_valid, 0);
        th1 = 32'h0000_C000; th2 = 32'h0001_0000;
        step(1);
        check("res_valid", out_valid, 1);
        check("res_theta1", out_theta1, 32'h0000_C000);
        check("res_theta2", out_theta2, 32'h0001_0000);
        check("res_txn", txn_cnt, 1);
        check("res_busy", busy, 0);

        // backpressure: offered request must not be taken
        th1 = 32'h1111_1111; th2 = 32'h2222_2222;
        in_valid = 1'b1; in_x = 32'h0000_9999;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("bp_valid", out_valid, 1);
            check("bp_theta1", out_theta1, 32'h0000_C000);
            check("bp_theta2", out_theta2, 32'h0001_0000);
            check("bp_in_ready", in_ready, 0);
            check("bp_core_x", core_x, 32'h0002_8000);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1 check("bp_ready_comb", in_ready, 1);
        step(1);
        check("bp_retired", out_valid, 0);
        check("bp_idle", busy, 0);

        // back-to-back with out_ready high: one result every LAT+1 edges
        in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_x = 32'h0000_1000 * k; th1 = 32'h11 * k; th2 = 32'h22 * k;
            step(1);
            check("b2b_core_x", core_x, 32'h0000_1000 * k);
            check("b2b_busy", busy, 1);
            check("b2b_gap", out_valid, 0);
            step(LAT - 1);
            check("b2b_early", out_valid, 0);
            step(1);
            check("b2b_valid", out_valid, 1);
            check("b2b_theta1", out_theta1, 32'h11 * k);
            check("b2b_theta2", out_theta2, 32'h22 * k);
            check("b2b_txn", txn_cnt, 1 + k);
        end
        in_valid = 1'b0;
        step(1);
        check("b2b_drain", out_valid, 0);

        // reset with the settle counter at 2
        in_valid = 1'b1; in_x = 32'h0000_5000;
        step(1);
        in_valid = 1'b0;
        step(1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_core_x", core_x, 0);
        check("mid_rst_txn", txn_cnt, 0);
        check("mid_rst_in_ready", in_ready, 0);
        step(1);
        rst = 1'b0;
        step(6);
        check("mid_rst_no_out", out_valid, 0);
        in_valid = 1'b1; in_x = 32'h0000_7000; in_y = 32'h0000_7100;
        th1 = 32'h8000_4000; th2 = 32'h0000_0001;
        step(1);
        in_valid = 1'b0;
        step(LAT);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_theta1", out_theta1, 32'h8000_4000);
        check("post_rst_txn", txn_cnt, 1);
        step(1);
        in_valid = 1'b0;
        step(1);
        check("post_rst_retired", out_valid, 0);

`ifdef IK_REACH_CHECK_EN
        out_ready = 1'b0;
        in_valid = 1'b1; in_x = 32'h000C_0000; in_y = 32'h0000_8000;
        step(1);
        in_valid = 1'b0;
        check("rej_far_valid", out_valid, 1);
        check("rej_far_err", out_err, 1);
        check("rej_far_theta1", out_theta1, 0);
        check("rej_far_core_x", core_x, 32'h0000_7000);
        check("rej_far_txn", txn_cnt, 2);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_x = 32'h8000_0000; in_y = 32'h0000_0000;
        step(1);
        in_valid = 1'b0;
        check("rej_zero_err", out_err, 1);
        check("rej_zero_theta2", out_theta2, 0);
        check("rej_zero_txn", txn_cnt, 3);
        out_ready = 1'b1;
        step(1);
        in_valid = 1'b1; in_x = 32'h0002_8000; in_y = 32'h000B_8000; th1 = 32'h0000_C000;
        step(1);
        in_valid = 1'b0;
        check("ok_busy", busy, 1);
        step(LAT);
        check("ok_valid", out_valid, 1);
        check("ok_err", out_err, 0);
        check("ok_theta1", out_theta1, 32'h0000_C000);
        check("ok_txn", txn_cnt, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ik_request_sequencer.md
Name: ik_request_sequencer

Overview:
- Handshake front end for the combinational/multicycle inverse-kinematics kernel, which has no valid/ready signals.
- Accepts one (x, y) target per transaction on a valid/ready input port.
- Drives the kernel's x/y inputs and holds them stable for a programmed settle latency, then captures theta1/theta2 into an output register with valid/ready.
- Sits directly upstream of the kernel and wraps its outputs. Also keeps a transaction counter for the testbench and debug.

Parameters:
- BIT_WIDTH, 32, data width; fixed-point sign-magnitude, same format as qadd/qmult.
- FRACTIONS, 15, fractional bits (1.0 = 0x0000_8000).
- LATENCY, 100, cycles the kernel inputs are held stable before results are sampled; legal range 1..2^LAT_W-1.
- LAT_W, 8, settle counter width.
- CNT_W, 16, transaction counter width.

Ports:
- clock  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when high together with in_valid.
- in_x  in  BIT_WIDTH  target x.
- in_y  in  BIT_WIDTH  target y.
- core_x  out  BIT_WIDTH  x to kernel.
- core_y  out  BIT_WIDTH  y to kernel.
- core_theta1  in  BIT_WIDTH  theta1 from kernel.
- core_theta2  in  BIT_WIDTH  theta2 from kernel.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when high with out_valid.
- out_theta1  out  BIT_WIDTH  captured theta1.
- out_theta2  out  BIT_WIDTH  captured theta2.
- busy  out  1  high in RUN state.
- txn_cnt  out  CNT_W  completed transactions, wraps.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0.
  - Outputs: core_x=0, core_y=0, out_theta1=0, out_theta2=0, out_valid=0, busy=0, txn_cnt=0.
  - Reset mid-RUN abandons the transaction; no output is produced.
- States: IDLE, RUN, OUT.
- in_ready is combinational: 1 in IDLE, or in OUT when out_ready=1. It is 0 in RUN and during reset.
- Accept (in_valid & in_ready at a rising edge):
  - core_x<=in_x, core_y<=in_y, counter<=LATENCY-1, state<=RUN.
  - If accepted from OUT, the pending result is retired on the same edge: out_valid<=0 and the new request starts (back-to-back, no bubble).
- RUN:
  - Each edge with counter!=0 decrements the counter.
  - On the edge where counter==0: out_theta1<=core_theta1, out_theta2<=core_theta2, out_valid<=1, txn_cnt<=txn_cnt+1, state<=OUT.
  - out_valid therefore rises exactly LATENCY edges after the accept edge.
- OUT:
  - out_valid and out_theta* are held stable until out_ready=1.
  - On that edge, out_valid<=0 and state<=IDLE, unless a new accept occurs on the same edge (then RUN).
- core_x/core_y change only on accept and hold their last value in IDLE and OUT, so the kernel never sees glitching inputs.
- in_x/in_y are ignored when not accepted. in_valid may drop without being accepted (no protocol error).
- busy = (state==RUN).
- txn_cnt wraps from 2^CNT_W-1 to 0.
- No arithmetic on the data path; values pass bit-exact.

Optional Feature:
- Macro: IK_REACH_CHECK_EN.
- Defined:
  - On accept, the input magnitudes (bits [BIT_WIDTH-2:0]) are checked.
  - A request is rejected if |x| > 23.0 (0x000B_8000) or |y| > 23.0, or if x and y magnitudes are both zero (this would divide by zero in the kernel).
  - A rejected request skips RUN and goes directly to OUT on the accept edge with out_theta1=out_theta2=0 and out_err=1. core_x/core_y keep their previous value. txn_cnt still increments.
  - Adds output port out_err (1 bit), reset 0. It is captured alongside out_theta* and is 0 for normal results.
- Not defined: no check, no out_err port; every request runs LATENCY cycles.

Test Plan:
- Reset/idle: assert rst mid-cycle -> all outputs 0 immediately; in_ready=1 after release; out_valid stays 0 with no input.
- Single transaction, LATENCY=4, kernel stub returns theta1=0x0000_C000, theta2=0x0001_0000:
  - Accept x=0x0002_8000, y=0x0003_0000 at edge E -> core_x/core_y update at E.
  - out_valid=1 after edge E+4 with the stub values; txn_cnt=1.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_theta* stable, in_ready=0; raise out_ready -> out_valid drops on the next edge.
- Back-to-back: in_valid held high, out_ready=1, LATENCY=4 -> a result every 5 cycles, no bubbles beyond that; txn_cnt counts 1,2,3.
- Reset during RUN (counter=2) -> no out_valid; next request completes normally with txn_cnt=1.
- IK_REACH_CHECK_EN defined, x=0x000C_0000 (24.0) -> out_valid=1 on the edge after accept with out_err=1 and theta=0. x=y=0 -> same. x=0x0002_8000 -> out_err=0 and normal latency.
